rggen_pipelined_reducer: RTL
============================

Name: rggen_pipelined_reducer

Overview:
- Parametrised, pipelined N-input bitwise reduction tree (OR / AND / XOR) with a valid/ready handshake on both sides.
- Successor to the combinational OR reducer, and uses the same fan-in-4 grouping.
- Adds selectable operation, configurable register insertion between tree levels, and per-stage backpressure.
- Used to merge wide per-register status/interrupt vectors where a single-cycle tree fails timing.

Parameters:
- WIDTH, 2, bit width of each input element and of the result.
- N, 1, number of input elements, >= 1.
- OPERATION, 0, reduction operator: 0 = OR, 1 = AND, 2 = XOR. Any other value is an elaboration error.
- REGISTER_INTERVAL, 1, tree levels per pipeline register. 0 = fully combinational.

Ports:
- i_clk  input  1  clock.
- i_rst  input  1  synchronous, active-high reset.
- i_valid  input  1  input data valid.
- o_ready  output  1  block can accept i_data this cycle.
- i_data  input  [N-1:0][WIDTH-1:0]  elements to reduce.
- o_valid  output  1  o_result valid.
- i_ready  input  1  downstream accepts o_result.
- o_result  output  [WIDTH-1:0]  reduced value.

Behaviour:
- One clock (i_clk); reset is synchronous and active-high (i_rst).
- Tree levels. Each level splits the current count n into groups, starting at element 0:
  - remaining > 4 and remaining/2 <= 4: group size is remaining/2;
  - otherwise, if remaining >= 4: group size is 4;
  - otherwise: group size is the remainder.
- Each group reduces to one element; repeat until one element remains.
- LEVELS: N=1 gives 1 (pass-through level). Examples: N=2 -> 1, N=5 -> 2, N=16 -> 2, N=17 -> 3.
- Pipeline stages P = 0 if REGISTER_INTERVAL == 0, else ceil(LEVELS / REGISTER_INTERVAL).
- Register placement: after level k*REGISTER_INTERVAL, and after the final level if that is not aligned. The last register drives o_result/o_valid directly.
- Latency: an accepted transfer (i_valid && o_ready) appears on o_valid exactly P cycles later if no stall occurs. Throughput is one transfer per cycle.
- Each stage s holds valid_q[s] and data_q[s].
  - Stage ready: ready[s] = !valid_q[s] || ready[s+1], with ready[P] = i_ready.
  - Stage loads when ready[s]: valid_q[s] <= upstream valid, data_q[s] <= upstream data.
  - Otherwise the stage holds.
  - o_ready = ready[0]. Bubbles collapse; the ready path is combinational through all stages.
- Data registers update only when stage valid is loaded as 1. They retain their value otherwise, which saves toggling.
- P = 0: o_valid = i_valid, o_ready = i_ready, o_result = combinational reduction.
- AND with N=1 and XOR with N=1: o_result = i_data[0].
- Reset: all valid_q = 0 and all data_q = '0. So o_valid = 0, o_result = '0; o_ready = 1 when P > 0.
- Reset mid-operation: in-flight items are discarded. No output transfer on the cycle after reset is asserted.
- Simultaneous output accept and new input with a full pipe: the pipe advances by one with no loss or duplication.
- i_valid without acceptance: source must hold i_data stable until accepted. The block does not check this.
- Valid holding: the block never drops o_valid without i_ready.

Decomposition:
- Shared package rggen_reducer_pkg holds:
  - enum rggen_reduce_op_e (RGGEN_REDUCE_OR/AND/XOR);
  - constant functions get_sub_n_list, get_offset_list, get_next_n, get_levels;
  - function get_stage_count.
- Sub-module rggen_reducer_level: one combinational tree level (N_IN, WIDTH, OPERATION -> N_OUT elements), instantiated LEVELS times in a generate loop.
- Pipeline registers are interleaved per REGISTER_INTERVAL.

Test Plan:
- OR, N=16, WIDTH=8, INTERVAL=1 (P=2), i_ready=1. Drive element 5 = 8'h01, element 12 = 8'h80, all others 0. Require o_result = 8'h81 with o_valid exactly 2 cycles after acceptance.
- AND, N=5, WIDTH=4, INTERVAL=1. Drive all elements 4'hF except element 4 = 4'hE. Require 4'hE after 2 cycles. Then drive all 4'hF: require 4'hF on the next cycle (back-to-back).
- XOR, N=17, WIDTH=1, INTERVAL=2 (LEVELS=3, P=2). Drive a stream of 8 random vectors. Require each o_result to equal the parity of its vector, in order, one per cycle.
- Backpressure: OR, N=16, P=2. Hold i_ready=0 for 4 cycles while i_valid=1. Require o_ready to drop to 0 after 2 accepts. Release: require all 3 results in order, with no loss or duplication.
- Reset mid-stream: assert i_rst for one cycle with 2 items in flight. Require o_valid=0 and o_result='0 on the next cycle, and o_ready=1.
- INTERVAL=0, N=3, OR. Require o_result to follow i_data combinationally and o_valid = i_valid, o_ready = i_ready.

Source files
------------

// File: rtl/rggen_reducer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rggen_reducer_pkg
// Description : Operator enum and constant functions describing the fan-in-4
//               reduction tree shape shared by the reducer blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package rggen_reducer_pkg;

    typedef enum logic [1:0] {
        RGGEN_REDUCE_OR  = 2'd0,
        RGGEN_REDUCE_AND = 2'd1,
        RGGEN_REDUCE_XOR = 2'd2
    } rggen_reduce_op_e;

    localparam int C_MAX_GROUPS = 1024;

    typedef logic [C_MAX_GROUPS-1:0][15:0] rggen_group_list_t;

    // Groups of 5..9 split in two halves so the next level never sees a lone element.
    function automatic int get_group_size(input int remaining);
        if ((remaining > 4) && ((remaining / 2) <= 4)) begin
            return remaining / 2;
        end else if (remaining >= 4) begin
            return 4;
        end else begin
            return remaining;
        end
    endfunction

    function automatic int get_next_n(input int n);
        int count;
        int remaining;
        count     = 0;
        remaining = n;
        while (remaining > 0) begin
            remaining = remaining - get_group_size(remaining);
            count     = count + 1;
        end
        return count;
    endfunction

    function automatic rggen_group_list_t get_sub_n_list(input int n);
        rggen_group_list_t list;
        int                remaining;
        int                idx;
        list      = '0;
        remaining = n;
        idx       = 0;
        while (remaining > 0) begin
            list[idx] = 16'(get_group_size(remaining));
            remaining = remaining - get_group_size(remaining);
            idx       = idx + 1;
        end
        return list;
    endfunction

    function automatic rggen_group_list_t get_offset_list(input int n);
        rggen_group_list_t list;
        int                remaining;
        int                offset;
        int                idx;
        list      = '0;
        remaining = n;
        offset    = 0;
        idx       = 0;
        while (remaining > 0) begin
            list[idx] = 16'(offset);
            offset    = offset + get_group_size(remaining);
            remaining = remaining - get_group_size(remaining);
            idx       = idx + 1;
        end
        return list;
    endfunction

    // A single element still costs one pass-through level.
    function automatic int get_levels(input int n);
        int levels;
        int current;
        levels  = 0;
        current = n;
        do begin
            current = get_next_n(current);
            levels  = levels + 1;
        end while (current > 1);
        return levels;
    endfunction

    function automatic int get_level_n(input int n, input int level);
        int current;
        current = n;
        for (int i = 0; i < level; i++) begin
            current = get_next_n(current);
        end
        return current;
    endfunction

    function automatic int get_node_offset(input int n, input int level);
        int offset;
        offset = 0;
        for (int i = 0; i < level; i++) begin
            offset = offset + get_level_n(n, i);
        end
        return offset;
    endfunction

    function automatic int get_stage_count(input int n, input int interval);
        if (interval <= 0) begin
            return 0;
        end
        return (get_levels(n) + interval - 1) / interval;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rggen_reducer_level.sv
`default_nettype none
// ============================================================================
// Module      : rggen_reducer_level
// Description : One combinational level of the reduction tree.
// Revision    : 1.0 - initial release
// ============================================================================
module rggen_reducer_level
    import rggen_reducer_pkg::*;
#(
    parameter  int N_IN      = 1,
    parameter  int WIDTH     = 2,
    parameter  int OPERATION = 0,
    localparam int N_OUT     = get_next_n(N_IN)
) (
    input  logic [N_IN-1:0][WIDTH-1:0]  i_data,
    output logic [N_OUT-1:0][WIDTH-1:0] o_data
);

    localparam rggen_reduce_op_e  C_OP     = rggen_reduce_op_e'(OPERATION[1:0]);
    localparam rggen_group_list_t C_SUB_N  = get_sub_n_list(N_IN);
    localparam rggen_group_list_t C_OFFSET = get_offset_list(N_IN);

    for (genvar g = 0; g < N_OUT; g++) begin : g_group
        localparam int C_SIZE = int'(C_SUB_N[g]);
        localparam int C_BASE = int'(C_OFFSET[g]);

        logic [WIDTH-1:0] w_acc;

        always_comb begin
            w_acc = i_data[C_BASE];
            for (int i = 1; i < C_SIZE; i++) begin
                case (C_OP)
                    RGGEN_REDUCE_AND: w_acc = w_acc & i_data[C_BASE+i];
                    RGGEN_REDUCE_XOR: w_acc = w_acc ^ i_data[C_BASE+i];
                    default:          w_acc = w_acc | i_data[C_BASE+i];
                endcase
            end
        end

        assign o_data[g] = w_acc;
    end

endmodule
`default_nettype wire

// File: rtl/rggen_pipelined_reducer.sv
`default_nettype none
// ============================================================================
// Module      : rggen_pipelined_reducer
// Description : Pipelined N-input OR/AND/XOR reduction tree with valid/ready
//               handshake and per-stage backpressure.
// Revision    : 1.0 - initial release
// ============================================================================
module rggen_pipelined_reducer
    import rggen_reducer_pkg::*;
#(
    parameter int WIDTH             = 2,
    parameter int N                 = 1,
    parameter int OPERATION         = 0,
    parameter int REGISTER_INTERVAL = 1
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_valid,
    output logic                      o_ready,
    input  logic [N-1:0][WIDTH-1:0]   i_data,
    output logic                      o_valid,
    input  logic                      i_ready,
    output logic [WIDTH-1:0]          o_result
);

    localparam int C_LEVELS      = get_levels(N);
    localparam int C_STAGES      = get_stage_count(N, REGISTER_INTERVAL);
    localparam int C_STAGE_SLOTS = (C_STAGES > 0) ? C_STAGES : 1;
    localparam int C_NODE_COUNT  = get_node_offset(N, C_LEVELS + 1);
    localparam int C_INTERVAL    = (REGISTER_INTERVAL > 0) ? REGISTER_INTERVAL : 1;

    if ((OPERATION < 0) || (OPERATION > 2)) begin : g_bad_operation
        $error("rggen_pipelined_reducer: OPERATION must be 0 (OR), 1 (AND) or 2 (XOR)");
    end
    if ((N < 1) || (REGISTER_INTERVAL < 0)) begin : g_bad_shape
        $error("rggen_pipelined_reducer: N must be >= 1 and REGISTER_INTERVAL >= 0");
    end

    // Every level's input elements and output elements live in flat buses,
    // each level occupying a contiguous slice.
    logic [C_NODE_COUNT*WIDTH-1:0]     w_level_in;
    logic [(C_NODE_COUNT-N)*WIDTH-1:0] w_level_out;
    logic [C_STAGE_SLOTS-1:0]          w_valid;
    logic [C_STAGE_SLOTS-1:0]          w_ready;

    assign w_level_in[N*WIDTH-1:0] = i_data;

    for (genvar l = 0; l < C_LEVELS; l++) begin : g_level
        localparam int  C_N_IN     = get_level_n(N, l);
        localparam int  C_N_OUT    = get_level_n(N, l + 1);
        localparam int  C_IN_LSB   = get_node_offset(N, l) * WIDTH;
        localparam int  C_NEXT_LSB = get_node_offset(N, l + 1) * WIDTH;
        localparam int  C_OUT_LSB  = C_NEXT_LSB - (N * WIDTH);
        localparam int  C_STAGE    = l / C_INTERVAL;
        localparam bit  C_REG      = (REGISTER_INTERVAL > 0) &&
                                     ((((l + 1) % C_INTERVAL) == 0) || (l == (C_LEVELS - 1)));

        rggen_reducer_level #(
            .N_IN      (C_N_IN),
            .WIDTH     (WIDTH),
            .OPERATION (OPERATION)
        ) u_level (
            .i_data (w_level_in[C_IN_LSB +: C_N_IN*WIDTH]),
            .o_data (w_level_out[C_OUT_LSB +: C_N_OUT*WIDTH])
        );

        if (C_REG) begin : g_register
            logic                     r_valid;
            logic [C_N_OUT*WIDTH-1:0] r_data;
            logic                     w_up_valid;

            if (C_STAGE == 0) begin : g_first
                assign w_up_valid = i_valid;
            end else begin : g_inner
                assign w_up_valid = w_valid[C_STAGE-1];
            end

            // Data only moves when a real item is loaded, keeping idle stages quiet.
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    r_valid <= 1'b0;
                    r_data  <= '0;
                end else if (w_ready[C_STAGE]) begin
                    r_valid <= w_up_valid;
                    if (w_up_valid) begin
                        r_data <= w_level_out[C_OUT_LSB +: C_N_OUT*WIDTH];
                    end
                end
            end

            assign w_valid[C_STAGE]                          = r_valid;
            assign w_level_in[C_NEXT_LSB +: C_N_OUT*WIDTH]   = r_data;
        end else begin : g_bypass
            assign w_level_in[C_NEXT_LSB +: C_N_OUT*WIDTH] =
                w_level_out[C_OUT_LSB +: C_N_OUT*WIDTH];
        end
    end

    if (C_STAGES == 0) begin : g_comb
        assign w_valid[0] = i_valid;
        assign w_ready[0] = i_ready;
    end else begin : g_pipe
        // Unrolled ready chain: a stage can load if any stage at or after it is empty.
        for (genvar s = 0; s < C_STAGES; s++) begin : g_ready
            assign w_ready[s] = i_ready || !(&w_valid[C_STAGES-1:s]);
        end
    end

    assign o_ready  = w_ready[0];
    assign o_valid  = w_valid[C_STAGE_SLOTS-1];
    assign o_result = w_level_in[C_NODE_COUNT*WIDTH-1 -: WIDTH];

endmodule
`default_nettype wire
